des_init_perm_stage: RTL
========================

// Module: des_init_perm_stage
// PURPOSE
// - Front-end pipeline stage of the DES datapath: applies the DES Initial Permutation (IP), the forward
//   counterpart of the final inverse permutation, to one 64-bit block per transfer and splits it into L0/R0.
// - Sits between the block-input interface and round 1; valid/ready on both sides, 1-cycle latency.
// - Holds up to 2 blocks (main + skid register), so full throughput is kept with a registered in_ready.
// PARAMETERS
// - SKID_EN  1  1: 2-entry skid buffer, in_ready registered; 0: single register, in_ready = !out_valid | out_ready
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   asynchronous, active-low reset
// - in_valid   in   1   in_block valid
// - in_ready   out  1   stage can accept in_block this cycle
// - in_block   in   64  plaintext/ciphertext block; index i = DES bit i+1 (DES bit 1 at [0])
// - out_valid  out  1   out_l/out_r valid
// - out_ready  in   1   downstream accepts this cycle
// - out_l      out  32  L0 = IP result [31:0] (DES bits 1..32)
// - out_r      out  32  R0 = IP result [63:32] (DES bits 33..64)
// - occ        out  2   blocks held (0..2; max 1 when SKID_EN=0)
// - chk_err    out  1   sticky self-check failure (see CONFIGURATION)
// BEHAVIOUR
// - IP: p[i] = in_block[IP[i]-1], IP (i=0..63) = 58 50 42 34 26 18 10 2 60 52 44 36 28 20 12 4
//   62 54 46 38 30 22 14 6 64 56 48 40 32 24 16 8 57 49 41 33 25 17 9 1 59 51 43 35 27 19 11 3
//   61 53 45 37 29 21 13 5 63 55 47 39 31 23 15 7. Permutation is purely wiring; registered once.
// - Reset (async assert, sync deassert by caller): out_valid=0, occ=0, out_l=out_r=0, skid empty,
//   chk_err=0, in_ready=1 (both SKID_EN values); any held blocks are discarded.
// - Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready. Latency: accepted in cycle N
//   -> out_valid with data in cycle N+1 (main register empty or draining).
// - Stall: while out_valid & !out_ready, out_l/out_r/out_valid hold stable; no block lost or duplicated.
// - SKID_EN=1: block accepted while main full and not draining goes to skid; in_ready(next) = skid empty.
//   On drain, skid moves into main next cycle. in_ready never depends combinationally on out_ready.
// - Simultaneous accept+drain, main full, skid empty: new block enters main, occ stays 1.
// - Full (occ=2): in_ready=0; in_valid ignored. Drain in that cycle -> occ=1, in_ready=1 next cycle.
// - Order: blocks leave strictly in acceptance order.
// - occ: +1 on accept only, -1 on drain only, unchanged on both/neither; never wraps.
// - in_valid while in_ready=0: no state change; source must hold in_block stable (not checked).
// CONFIGURATION
// - Macro DES_IP_SELFCHECK_EN:
//   defined: each entry also stores raw in_block; inverse permutation of {out_r,out_l} compared to stored
//   raw block whenever out_valid; mismatch sets chk_err=1, sticky until rst_n low. Adds 64 bits/entry.
//   undefined: no raw storage or comparator; chk_err tied 0. Ports identical in both builds.
// TESTING
// - Reset: rst_n=0 mid-stream with occ=2 -> out_valid=0, occ=0, in_ready=1, out_l=out_r=0 immediately.
// - Single bit: in_block=64'h1 -> next cycle out_r=32'h0000_0080, out_l=0; in_block=1<<57 -> out_l=32'h1, out_r=0.
// - Patterns: 64'hFFFF_FFFF_FFFF_FFFF -> out_l=out_r=32'hFFFF_FFFF; 64'h0 -> both 0; 1-cycle latency each.
// - Back-pressure: stream 4 blocks, out_ready=0 for 3 cycles -> occ=2, in_ready=0, outputs stable;
//   release -> all 4 delivered in order, none dropped or duplicated.
// - Throughput: in_valid=out_ready=1 for 100 random blocks -> one output per cycle, occ<=1, each equals IP(in).
// - Self-check build: 1000 random blocks with random stalls -> chk_err stays 0; non-selfcheck build chk_err=0.

Source files
------------

// File: rtl/des_init_perm_stage.sv
// DES Initial Permutation front-end stage: IP applied to a 64-bit block, split into L0/R0, valid/ready with
// optional skid entry (SKID_EN). Define DES_IP_SELFCHECK_EN to store raw blocks and flag inverse-IP mismatches.
module des_init_perm_stage #(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_l,
    output logic [31:0] out_r,
    output logic [1:0]  occ,
    output logic        chk_err
);

    // Bit i of the result takes DES bit IP_TBL[i] (in_block bit IP_TBL[i]-1).
    localparam int unsigned IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    function automatic logic [63:0] ip_fwd(input logic [63:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) p[i] = b[IP_TBL[i] - 1];
        return p;
    endfunction

    logic        main_vld_q, main_vld_d;
    logic        skid_vld_q, skid_vld_d;
    logic [63:0] main_q, main_d;
    logic [63:0] skid_q, skid_d;
    logic        accept, drain;
    logic        load_main_in, load_main_skid, load_skid;
    logic [63:0] perm;

    assign in_ready  = SKID_EN ? ~skid_vld_q : (~main_vld_q | out_ready);
    assign out_valid = main_vld_q;
    assign out_l     = main_q[31:0];
    assign out_r     = main_q[63:32];
    assign occ       = {skid_vld_q, main_vld_q & ~skid_vld_q};

    assign accept = in_valid & in_ready;
    assign drain  = main_vld_q & out_ready;
    assign perm   = ip_fwd(in_block);

    // Skid can only be occupied while main is, so a drain always refills main from skid first.
    assign load_main_skid = drain & skid_vld_q;
    assign load_main_in   = accept & (~main_vld_q | (drain & ~skid_vld_q));
    assign load_skid      = accept & main_vld_q & ~drain;

    always_comb begin
        main_vld_d = load_main_in | load_main_skid | (main_vld_q & ~drain);
        skid_vld_d = load_skid | (skid_vld_q & ~load_main_skid);
        main_d     = main_q;
        skid_d     = skid_q;
        if (load_main_skid)    main_d = skid_q;
        else if (load_main_in) main_d = perm;
        if (load_skid)         skid_d = perm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef DES_IP_SELFCHECK_EN
    function automatic logic [63:0] ip_inv(input logic [63:0] p);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) b[IP_TBL[i] - 1] = p[i];
        return b;
    endfunction

    logic [63:0] raw_main_q, raw_main_d;
    logic [63:0] raw_skid_q, raw_skid_d;
    logic        chk_err_q, chk_err_d;

    always_comb begin
        raw_main_d = raw_main_q;
        raw_skid_d = raw_skid_q;
        if (load_main_skid)    raw_main_d = raw_skid_q;
        else if (load_main_in) raw_main_d = in_block;
        if (load_skid)         raw_skid_d = in_block;
        chk_err_d = chk_err_q | (main_vld_q & (ip_inv(main_q) != raw_main_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_main_q <= '0;
            raw_skid_q <= '0;
            chk_err_q  <= 1'b0;
        end else begin
            raw_main_q <= raw_main_d;
            raw_skid_q <= raw_skid_d;
            chk_err_q  <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
